// File: rtl/player_pkg.sv
// Shared definitions for the player motion engine, also used by the
// collision and sprite renderer logic.
package player_pkg;

  typedef enum logic [1:0] {
    ST_MENU  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  // at_edge bit positions: {left,right,up,down}
  localparam int unsigned EDGE_L = 3;
  localparam int unsigned EDGE_R = 2;
  localparam int unsigned EDGE_U = 1;
  localparam int unsigned EDGE_D = 0;

endpackage

// File: rtl/player_motion_axis_step.sv
// Combinational single-axis step: moves pos by +/-speed according to the
// opposing buttons and saturates the result to [min_i, max_i].
module axis_step #(
  parameter int WIDTH = 10
) (
  input  logic [WIDTH-1:0] pos_i,
  input  logic [WIDTH-1:0] speed_i,
  input  logic             neg_i,
  input  logic             pos_dir_i,
  input  logic [WIDTH-1:0] min_i,
  input  logic [WIDTH-1:0] max_i,
  output logic [WIDTH-1:0] next_o,
  output logic             changed_o,
  output logic             at_min_o,
  output logic             at_max_o
);

  localparam int SW = WIDTH + 2;

  logic signed [SW-1:0] pos_s;
  logic signed [SW-1:0] spd_s;
  logic signed [SW-1:0] min_s;
  logic signed [SW-1:0] max_s;
  logic signed [SW-1:0] sum_s;

  assign pos_s = signed'({2'b00, pos_i});
  assign spd_s = signed'({2'b00, speed_i});
  assign min_s = signed'({2'b00, min_i});
  assign max_s = signed'({2'b00, max_i});

  // Step in the held direction with two guard bits, then clamp to the bounds.
  always_comb begin
    sum_s  = pos_s;
    next_o = pos_i;
    if (neg_i ^ pos_dir_i) begin
      sum_s = pos_dir_i ? (pos_s + spd_s) : (pos_s - spd_s);
      if (sum_s < min_s)
        next_o = min_i;
      else if (sum_s > max_s)
        next_o = max_i;
      else
        next_o = sum_s[WIDTH-1:0];
    end
    changed_o = (next_o != pos_i);
    at_min_o  = (next_o == min_i);
    at_max_o  = (next_o == max_i);
  end

endmodule

// File: rtl/player_motion.sv
// Player sprite motion engine: mode FSM, move-tick divider and clamped
// position registers. Define PLAYER_ACCEL_EN to ramp speed from STEP up to
// STEP_MAX while a direction is held; otherwise speed is the constant STEP.
module player_motion
  import player_pkg::*;
#(
  parameter int WIDTH    = 10,
  parameter int FIELD_W  = 640,
  parameter int FIELD_H  = 480,
  parameter int BORDER   = 15,
  parameter int RADIUS   = 25,
  parameter int START_X  = 320,
  parameter int START_Y  = 240,
  parameter int STEP     = 15,
  parameter int STEP_MAX = 24,
  parameter int TICK_DIV = 1666667
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up,
  input  logic             down,
  input  logic             left,
  input  logic             right,
  input  logic             gamemenu,
  input  logic             gamerun,
  input  logic             gamepause,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic             moved,
  output logic [3:0]       at_edge
);

  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [WIDTH-1:0] XMIN   = WIDTH'(BORDER + RADIUS);
  localparam logic [WIDTH-1:0] XMAX   = WIDTH'(FIELD_W - 1 - BORDER - RADIUS);
  localparam logic [WIDTH-1:0] YMIN   = WIDTH'(BORDER + RADIUS);
  localparam logic [WIDTH-1:0] YMAX   = WIDTH'(FIELD_H - 1 - BORDER - RADIUS);
  localparam logic [WIDTH-1:0] X_INIT = WIDTH'(START_X);
  localparam logic [WIDTH-1:0] Y_INIT = WIDTH'(START_Y);
  localparam logic [WIDTH-1:0] SPD0   = WIDTH'(STEP);
  localparam logic [3:0] START_EDGE = {X_INIT == XMIN, X_INIT == XMAX,
                                       Y_INIT == YMIN, Y_INIT == YMAX};

  state_e           state_q, state_d;
  logic [TW-1:0]    tick_cnt_q;
  logic [WIDTH-1:0] x_q, y_q, x_d, y_d;
  logic             moved_q;
  logic [3:0]       at_edge_q;
  logic [WIDTH-1:0] speed;
  logic             x_chg, y_chg, x_lo, x_hi, y_lo, y_hi;

`ifdef PLAYER_ACCEL_EN
  localparam logic [WIDTH-1:0] SPD_MAX = WIDTH'(STEP_MAX);
  logic [WIDTH-1:0] speed_q;
  logic             any_held;
  assign speed    = speed_q;
  assign any_held = up | down | left | right;
`else
  assign speed = SPD0;
`endif

  axis_step #(.WIDTH(WIDTH)) u_axis_x (
    .pos_i(x_q), .speed_i(speed), .neg_i(left), .pos_dir_i(right),
    .min_i(XMIN), .max_i(XMAX),
    .next_o(x_d), .changed_o(x_chg), .at_min_o(x_lo), .at_max_o(x_hi)
  );

  axis_step #(.WIDTH(WIDTH)) u_axis_y (
    .pos_i(y_q), .speed_i(speed), .neg_i(up), .pos_dir_i(down),
    .min_i(YMIN), .max_i(YMAX),
    .next_o(y_d), .changed_o(y_chg), .at_min_o(y_lo), .at_max_o(y_hi)
  );

  // Mode decode: only a single clean select picks MENU or RUN.
  always_comb begin
    state_d = ST_PAUSE;
    case ({gamemenu, gamerun, gamepause})
      3'b100:  state_d = ST_MENU;
      3'b010:  state_d = ST_RUN;
      default: state_d = ST_PAUSE;
    endcase
  end

  // FSM, tick divider, speed and registered outputs; current state sets the action.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_MENU;
      tick_cnt_q <= '0;
      x_q        <= X_INIT;
      y_q        <= Y_INIT;
      moved_q    <= 1'b0;
      at_edge_q  <= '0;
`ifdef PLAYER_ACCEL_EN
      speed_q    <= SPD0;
`endif
    end else begin
      state_q <= state_d;
      moved_q <= 1'b0;
      case (state_q)
        ST_MENU: begin
          x_q        <= X_INIT;
          y_q        <= Y_INIT;
          tick_cnt_q <= '0;
          at_edge_q  <= START_EDGE;
`ifdef PLAYER_ACCEL_EN
          speed_q    <= SPD0;
`endif
        end
        ST_RUN: begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_q <= '0;
            x_q        <= x_d;
            y_q        <= y_d;
            moved_q    <= x_chg | y_chg;
            at_edge_q  <= {x_lo, x_hi, y_lo, y_hi};
`ifdef PLAYER_ACCEL_EN
            if (!any_held)
              speed_q <= SPD0;
            else if (speed_q < SPD_MAX)
              speed_q <= speed_q + WIDTH'(1);
`endif
          end else begin
            tick_cnt_q <= tick_cnt_q + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign x       = x_q;
  assign y       = y_q;
  assign moved   = moved_q;
  assign at_edge = at_edge_q;

endmodule

// File: tb/tb_player_motion.sv
// Self-checking bench for player_motion (TICK_DIV=4). Build with
// +define+PLAYER_ACCEL_EN to exercise the acceleration variant.
module tb_player_motion;

  logic       clk = 1'b0;
  logic       rst, up, down, left, right, gamemenu, gamerun, gamepause;
  logic [9:0] x, y;
  logic       moved;
  logic [3:0] at_edge;

  int checks = 0;
  int passes = 0;

  // Reference model state
  int       m_mode;   // 0 menu, 1 run, 2 pause
  int       m_x, m_y, m_phase, m_speed;
  bit       m_moved, m_ticked;
  bit [3:0] m_edge;
  logic [24:0] exp_v, act_v;

  player_motion #(.TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .up(up), .down(down), .left(left), .right(right),
    .gamemenu(gamemenu), .gamerun(gamerun), .gamepause(gamepause),
    .x(x), .y(y), .moved(moved), .at_edge(at_edge)
  );

  always #5 clk = ~clk;

  function automatic int clampi(int v, int lo, int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  // One clock: advance the model with the inputs the DUT sees at this edge.
  task automatic clock_step();
    int dx, dy, nx, ny;
    @(posedge clk);
    m_ticked = 0;
    if (rst) begin
      m_mode = 0; m_x = 320; m_y = 240; m_phase = 0; m_speed = 15;
      m_moved = 0; m_edge = 4'b0000;
    end else begin
      m_moved = 0;
      if (m_mode == 0) begin
        m_x = 320; m_y = 240; m_phase = 0; m_speed = 15; m_edge = 4'b0000;
      end else if (m_mode == 1) begin
        if (m_phase == 3) begin
          m_phase = 0; m_ticked = 1;
          dx = int'(right) - int'(left);
          dy = int'(down) - int'(up);
          nx = (dx == 0) ? m_x : clampi(m_x + dx * m_speed, 40, 599);
          ny = (dy == 0) ? m_y : clampi(m_y + dy * m_speed, 40, 439);
          m_moved = (nx != m_x) || (ny != m_y);
          m_x = nx; m_y = ny;
          m_edge = {nx == 40, nx == 599, ny == 40, ny == 439};
`ifdef PLAYER_ACCEL_EN
          if (up || down || left || right) m_speed = (m_speed + 1 > 24) ? 24 : m_speed + 1;
          else m_speed = 15;
`endif
        end else begin
          m_phase++;
        end
      end
      if ({gamemenu, gamerun, gamepause} == 3'b100) m_mode = 0;
      else if ({gamemenu, gamerun, gamepause} == 3'b010) m_mode = 1;
      else m_mode = 2;
    end
    @(negedge clk);
    exp_v = {10'(m_x), 10'(m_y), m_moved, m_edge};
    act_v = {x, y, moved, at_edge};
  endtask

  task automatic set_mode(input bit mn, input bit rn, input bit ps);
    gamemenu = mn; gamerun = rn; gamepause = ps;
  endtask

  task automatic set_btn(input bit u, input bit d, input bit l, input bit r);
    up = u; down = d; left = l; right = r;
  endtask

  // Step until the model reports a move tick (bounded).
  task automatic wait_tick(input string name);
    int n = 0;
    do begin
      clock_step();
      n++;
    end while (!m_ticked && n < 8);
    checks++;
    if (!m_ticked) $display("FAIL %s tick_timeout cycles=%0d required<=4", name, n);
    else passes++;
  endtask

  task automatic test_reset();
    rst = 1; set_mode(0, 0, 0); set_btn(0, 0, 0, 0);
    clock_step(); clock_step();
    rst = 0; set_mode(1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      clock_step();
      checks++;
      if (act_v !== {10'd320, 10'd240, 1'b0, 4'b0000})
        $display("FAIL reset_menu act=%h req=%h", act_v, {10'd320, 10'd240, 1'b0, 4'b0000});
      else passes++;
    end
  endtask

  task automatic test_move_right();
    int seen;
    set_mode(0, 1, 0); set_btn(0, 0, 0, 1);
    for (int t = 1; t <= 3; t++) begin
      seen = 0;
      for (int c = 0; c < 5; c++) begin
        clock_step();
        seen += int'(moved);
        checks++;
        if (act_v !== exp_v) $display("FAIL right_model act=%h req=%h", act_v, exp_v);
        else passes++;
        if (m_ticked) break;
      end
`ifndef PLAYER_ACCEL_EN
      checks++;
      if (x !== 10'(320 + 15 * t) || y !== 10'd240 || seen != 1)
        $display("FAIL right_tick%0d x=%0d y=%0d pulses=%0d req x=%0d y=240 pulses=1",
                 t, x, y, seen, 320 + 15 * t);
      else passes++;
`endif
    end
  endtask

  task automatic test_left_wall();
    set_mode(0, 1, 0); set_btn(0, 0, 1, 0);
    for (int i = 0; i < 40 && m_x > 50; i++) wait_tick("left_approach");
    checks++;
    if (x !== 10'(m_x)) $display("FAIL left_approach act=%0d req=%0d", x, m_x);
    else passes++;
    wait_tick("left_hit");
    checks++;
    if (x !== 10'd40 || at_edge[3] !== 1'b1 || moved !== 1'b1)
      $display("FAIL left_hit x=%0d edgeL=%b moved=%b req x=40 edgeL=1 moved=1", x, at_edge[3], moved);
    else passes++;
    for (int i = 0; i < 2; i++) begin
      wait_tick("left_push");
      checks++;
      if (x !== 10'd40 || moved !== 1'b0 || at_edge !== 4'b1000)
        $display("FAIL left_push x=%0d moved=%b edge=%b req x=40 moved=0 edge=1000", x, moved, at_edge);
      else passes++;
    end
  endtask

  task automatic test_opposing_and_bad_mode();
    int x0, y0;
    set_btn(1, 1, 0, 1);
    x0 = m_x; y0 = m_y;
    wait_tick("opposing");
    checks++;
    if (y !== 10'(y0) || x !== 10'(x0 + 15) || act_v !== exp_v)
      $display("FAIL opposing x=%0d y=%0d req x=%0d y=%0d", x, y, x0 + 15, y0);
    else passes++;
    set_mode(1, 1, 0);
    clock_step();
    x0 = x; y0 = y;
    for (int i = 0; i < 10; i++) begin
      clock_step();
      checks++;
      if (x !== 10'(x0) || y !== 10'(y0) || moved !== 1'b0)
        $display("FAIL mode110_frozen x=%0d y=%0d moved=%b req x=%0d y=%0d moved=0", x, y, moved, x0, y0);
      else passes++;
    end
  endtask

  task automatic test_pause_resume_and_reset();
    set_mode(0, 1, 0); set_btn(0, 1, 0, 0);
    clock_step(); clock_step();
    set_mode(0, 0, 1);
    for (int i = 0; i < 10; i++) clock_step();
    set_mode(0, 1, 0);
    for (int i = 0; i < 9; i++) begin
      clock_step();
      checks++;
      if (act_v !== exp_v) $display("FAIL pause_resume act=%h req=%h", act_v, exp_v);
      else passes++;
    end
    rst = 1;
    clock_step();
    rst = 0;
    checks++;
    if (x !== 10'd320 || y !== 10'd240 || moved !== 1'b0 || at_edge !== 4'b0000)
      $display("FAIL run_reset x=%0d y=%0d moved=%b edge=%b req 320 240 0 0000", x, y, moved, at_edge);
    else passes++;
    // State after reset is MENU: one more cycle still reloads START even with buttons held.
    clock_step();
    checks++;
    if (x !== 10'd320 || y !== 10'd240)
      $display("FAIL reset_menu_state x=%0d y=%0d req 320 240", x, y);
    else passes++;
  endtask

`ifdef PLAYER_ACCEL_EN
  task automatic test_accel();
    int req[6] = '{335, 351, 368, 386, 405, 425};
    set_mode(1, 0, 0); set_btn(0, 0, 0, 0);
    clock_step(); clock_step();
    set_mode(0, 1, 0); set_btn(0, 0, 0, 1);
    clock_step();
    for (int t = 0; t < 6; t++) begin
      wait_tick("accel");
      checks++;
      if (x !== 10'(req[t])) $display("FAIL accel_tick%0d x=%0d req=%0d", t, x, req[t]);
      else passes++;
    end
    for (int t = 0; t < 6; t++) wait_tick("accel_sat");
    checks++;
    if (m_speed != 24 || act_v !== exp_v)
      $display("FAIL accel_sat act=%h req=%h", act_v, exp_v);
    else passes++;
    set_btn(0, 0, 0, 0);
    wait_tick("accel_release");
    set_btn(1, 0, 0, 0);
    begin
      int y0 = y;
      wait_tick("accel_repress");
      checks++;
      if (y !== 10'(y0 - 15)) $display("FAIL accel_repress y=%0d req=%0d", y, y0 - 15);
      else passes++;
    end
  endtask
`endif

  task automatic test_random();
    int r;
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 19);
      if (r == 0) set_mode(1, 0, 0);
      else if (r == 1) set_mode(0, 0, 1);
      else if (r == 2) set_mode(1, 1, 0);
      else set_mode(0, 1, 0);
      rst = ($urandom_range(0, 99) == 0);
      set_btn($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
      clock_step();
      checks++;
      if (act_v !== exp_v) $display("FAIL random cyc=%0d act=%h req=%h", i, act_v, exp_v);
      else passes++;
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_move_right();
    test_left_wall();
    test_opposing_and_bad_mode();
    test_pause_resume_and_reset();
`ifdef PLAYER_ACCEL_EN
    test_accel();
`endif
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
